// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   - funct3 encodings for loads and stores
//   - LSU bus-transaction state type
//   - alignment helper shared by the LSU and future cache path
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  // Access size comes from funct3[1:0]; unused encodings behave as words.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-result extraction.
// Ports:
//   word    in  32  full memory word
//   addr_lo in  2   byte offset of the access
//   funct3  in  3   load type (LB/LH/LW/LBU/LHU, others act as LW)
//   ext     out 32  extended load value
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    ext = {{16{half_sel[15]}}, half_sel};
      F3_BU:   ext = {24'd0, byte_sel};
      F3_HU:   ext = {16'd0, half_sel};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit of the 5-stage RV32I pipeline.
// Runs one valid/ready transaction per M-stage access and holds the pipeline
// with StallM until the access completes in DONE.
// Ports:
//   clk, rst                     clock, async active-high reset
//   ALUResultM/WriteDataM        byte address and unshifted store data
//   MemReadM/MemWriteM/funct3M   access type
//   StallM                       pipeline hold
//   ReadDataExtM                 extended load result (valid in DONE)
//   MisalignedM/BusErrM          one-cycle exception flags
//   dreq_*                       request channel (valid/ready)
//   drsp_valid/drsp_rdata        response / write acknowledge
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  output logic        StallM,
  output logic [31:0] ReadDataExtM,
  output logic        MisalignedM,
  output logic        BusErrM,
  output logic        dreq_valid,
  input  logic        dreq_ready,
  output logic        dreq_we,
  output logic [31:0] dreq_addr,
  output logic [31:0] dreq_wdata,
  output logic [3:0]  dreq_wstrb,
  input  logic        drsp_valid,
  input  logic [31:0] drsp_rdata
);

  localparam logic [8:0] TIMEOUT = 9'(RSP_TIMEOUT);

  lsu_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;

  logic        access, misaligned, start;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] ext_word;
  logic [8:0]  cnt_inc;

  assign access     = MemReadM | MemWriteM;
  assign misaligned = is_misaligned(funct3M, ALUResultM[1:0]);
  assign start      = access & ~misaligned;

  // Store data replicated across lanes; strobes pick the addressed bytes.
  always_comb begin
    case (funct3M[1:0])
      2'b00: begin
        lane_wdata = {4{WriteDataM[7:0]}};
        lane_strb  = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        lane_wdata = {2{WriteDataM[15:0]}};
        lane_strb  = ALUResultM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_wdata = WriteDataM;
        lane_strb  = 4'b1111;
      end
    endcase
  end

  load_extend u_load_extend (
    .word    (rdata_q),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .ext     (ext_word)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      f3_q      <= f3_d;
      we_q      <= we_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state and datapath capture
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    f3_d      = f3_q;
    we_d      = we_q;
    wstrb_d   = wstrb_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    cnt_inc   = {1'b0, cnt_q} + 9'd1;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          addr_d  = ALUResultM;
          f3_d    = funct3M;
          we_d    = MemWriteM;
          wdata_d = lane_wdata;
          wstrb_d = MemWriteM ? lane_strb : 4'b0000;
        end
      end
      REQ: begin
        if (dreq_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (drsp_valid) begin
          rdata_d = drsp_rdata;
          state_d = DONE;
        end else if (cnt_inc == TIMEOUT) begin
          // Abandon the access: result reads as zero, BusErrM flags DONE.
          rdata_d   = '0;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    StallM       = 1'b0;
    MisalignedM  = 1'b0;
    ReadDataExtM = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          StallM      = start;
          MisalignedM = access & misaligned;
        end
        REQ, WAIT: StallM = 1'b1;
        default:   ReadDataExtM = ext_word;
      endcase
    end
  end

  assign dreq_valid = (state_q == REQ);
  assign dreq_we    = we_q;
  assign dreq_addr  = {addr_q[31:2], 2'b00};
  assign dreq_wdata = wdata_q;
  assign dreq_wstrb = wstrb_q;
  assign BusErrM    = bus_err_q;

endmodule
